// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared geometry constants, tile type and skew helper for the deskew collector
package ctrl_pkg;

   localparam int LANES  = 4;
   localparam int NIB_W  = 4;
   localparam int WORD_W = 16;
   localparam int BEATS  = 4;

   // One tile: LANES words of WORD_W bits, word j at index j
   typedef logic [LANES-1:0][WORD_W-1:0] tile_t;

   // Nibble of word j carried on lane j during beat p; 2-bit arithmetic gives the mod 4 wrap
   function automatic logic [1:0] nib_sel(input logic [1:0] p, input logic [1:0] j);
      return p - j;
   endfunction

endpackage

// File: rtl/deskew_bank.sv
// rtl/deskew_bank.sv - one 4x16 tile register with per-lane nibble write and word read
module deskew_bank
   import ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rstn,
   input  logic              wr_en_i,
   input  logic [1:0]        beat_i,
   input  logic [WORD_W-1:0] data_i,
   input  logic [1:0]        rd_idx_i,
   output logic [WORD_W-1:0] rd_data_o
);

   tile_t tile_q;

   // Each lane drops its nibble into its own word at the de-skewed nibble position
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tile_q <= '0;
      end else if (wr_en_i) begin
         for (int j = 0; j < LANES; j++) begin
            tile_q[j][nib_sel(beat_i, 2'(j))*NIB_W +: NIB_W] <= data_i[j*NIB_W +: NIB_W];
         end
      end
   end

   assign rd_data_o = tile_q[rd_idx_i];

endmodule

// File: rtl/deskew_collector.sv
// rtl/deskew_collector.sv - reassembles skewed 4-beat tiles into aligned words over two banks
module deskew_collector
   import ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rstn,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              in_abort,
   output logic [WORD_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        out_idx,
   output logic              out_last
);

   logic [1:0]        full_q, full_d;
   logic              wr_bank_q, wr_bank_d;
   logic              rd_bank_q, rd_bank_d;
   logic [1:0]        beat_cnt_q, beat_cnt_d;
   logic [1:0]        rd_idx_q, rd_idx_d;
   logic              abort_q, abort_d;

   logic              accept;
   logic              rd_hs;
   logic [WORD_W-1:0] bank_rd_data [2];

   // A bank in collection is never full, so in_ready can only drop at a tile boundary
   assign in_ready  = !full_q[wr_bank_q];
   assign accept    = in_valid && in_ready;
   assign out_valid = full_q[rd_bank_q];
   assign out_data  = bank_rd_data[rd_bank_q];
   assign out_idx   = rd_idx_q;
   assign out_last  = out_valid && (rd_idx_q == 2'(BEATS-1));
   assign rd_hs     = out_valid && out_ready;
   assign in_abort  = abort_q;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      deskew_bank u_bank (
         .clk       (clk),
         .rstn      (rstn),
         .wr_en_i   (accept && (wr_bank_q == 1'(b))),
         .beat_i    (beat_cnt_q),
         .data_i    (in_data),
         .rd_idx_i  (rd_idx_q),
         .rd_data_o (bank_rd_data[b])
      );
   end

   // Next-state: beat counting, abort detection, full flags and bank pointers
   always_comb begin
      full_d     = full_q;
      wr_bank_d  = wr_bank_q;
      rd_bank_d  = rd_bank_q;
      beat_cnt_d = beat_cnt_q;
      rd_idx_d   = rd_idx_q;
      abort_d    = 1'b0;

      if (accept) begin
         beat_cnt_d = beat_cnt_q + 2'd1;
         if (beat_cnt_q == 2'(BEATS-1)) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
         end
      end else if (!in_valid && beat_cnt_q != 2'd0) begin
         // Partial tile is dropped; the bank stays not-full and is overwritten next tile
         beat_cnt_d = 2'd0;
         abort_d    = 1'b1;
      end

      // Set above and clear here always target different banks
      if (rd_hs) begin
         rd_idx_d = rd_idx_q + 2'd1;
         if (rd_idx_q == 2'(BEATS-1)) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
         end
      end
   end

   // Control state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         full_q     <= '0;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         beat_cnt_q <= '0;
         rd_idx_q   <= '0;
         abort_q    <= 1'b0;
      end else begin
         full_q     <= full_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         beat_cnt_q <= beat_cnt_d;
         rd_idx_q   <= rd_idx_d;
         abort_q    <= abort_d;
      end
   end

endmodule

// File: tb/tb_deskew_collector.sv
// tb/tb_deskew_collector.sv - scoreboard bench for deskew_collector
module tb_deskew_collector;

   logic        clk;
   logic        rstn;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        in_abort;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_idx;
   logic        out_last;

   deskew_collector dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_abort  (in_abort),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_last  (out_last)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [15:0] data;
      logic [1:0]  idx;
      logic        last;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   logic [15:0] beats [3][4];
   logic [15:0] words [3][4];
   int          n_vec = 0;
   int          n_miss = 0;
   int          hs_cnt = 0;
   int          abort_cnt = 0;
   int          total_wait = 0;
   int          hs0;
   int          abort0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_tile(input int t);
      for (int i = 0; i < 4; i++) begin
         sb_q.push_back('{data: words[t][i], idx: 2'(i), last: (i == 3)});
      end
   endtask

   task automatic send_beat(input logic [15:0] d);
      int w;
      w = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
      total_wait += w;
      @(posedge clk); #1;
   endtask

   task automatic send_tile(input int t);
      push_tile(t);
      for (int p = 0; p < 4; p++) send_beat(beats[t][p]);
   endtask

   task automatic wait_drain();
      int w;
      w = 0;
      while (sb_q.size() != 0 && w < 200) begin
         @(posedge clk); #1;
         w++;
      end
      check("drain", sb_q.size(), 0);
   endtask

   // Monitor: pop and compare every word handshake
   always @(negedge clk) begin
      if (rstn) begin
         if (in_abort) abort_cnt++;
         if (out_valid && out_ready) begin
            hs_cnt++;
            if (sb_q.size() == 0) begin
               check("unexpected_word", {16'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
               mon_e = sb_q.pop_front();
               check("word_data", out_data, mon_e.data);
               check("word_idx", out_idx, mon_e.idx);
               check("word_last", out_last, mon_e.last);
            end
         end
      end
   end

   initial begin
      beats[0][0] = 16'hDA70; beats[0][1] = 16'hEB41; beats[0][2] = 16'hF852; beats[0][3] = 16'hC963;
      words[0][0] = 16'h3210; words[0][1] = 16'h7654; words[0][2] = 16'hBA98; words[0][3] = 16'hFEDC;
      beats[1][0] = 16'hDCBA; beats[1][1] = 16'hDCBA; beats[1][2] = 16'hDCBA; beats[1][3] = 16'hDCBA;
      words[1][0] = 16'hAAAA; words[1][1] = 16'hBBBB; words[1][2] = 16'hCCCC; words[1][3] = 16'hDDDD;
      beats[2][0] = 16'hEB81; beats[2][1] = 16'hFC52; beats[2][2] = 16'h0963; beats[2][3] = 16'hDA74;
      words[2][0] = 16'h4321; words[2][1] = 16'h8765; words[2][2] = 16'hCBA9; words[2][3] = 16'h0FED;

      rstn = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_idx", out_idx, 0);
      check("rst_out_last", out_last, 0);
      check("rst_in_abort", in_abort, 0);
      rstn = 1'b1;
      @(posedge clk); #1;

      // Single tile with first-word latency
      out_ready = 1'b1;
      send_tile(0);
      in_valid = 1'b0;
      check("lat_out_valid", out_valid, 1);
      check("lat_out_idx", out_idx, 0);
      wait_drain();

      // Three tiles back-to-back, no input stalls and no output gaps
      total_wait = 0;
      hs0 = hs_cnt;
      send_tile(0);
      send_tile(1);
      send_tile(2);
      in_valid = 1'b0;
      check("b2b_in_stall", total_wait, 0);
      check("b2b_words_8", hs_cnt - hs0, 8);
      repeat (4) @(posedge clk);
      #1;
      check("b2b_words_12", hs_cnt - hs0, 12);

      // Backpressure: both banks fill, 9th beat held, drain restores in_ready
      out_ready = 1'b0;
      send_tile(0);
      send_tile(2);
      check("bp_ready_low", in_ready, 0);
      push_tile(1);
      in_valid = 1'b1;
      in_data  = beats[1][0];
      repeat (3) @(posedge clk);
      #1;
      check("bp_ready_held", in_ready, 0);
      check("bp_valid_stall", out_valid, 1);
      check("bp_data_stable", out_data, 16'h3210);
      check("bp_idx_stable", out_idx, 0);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("bp_ready_before4", in_ready, 0);
      @(posedge clk); #1;
      check("bp_ready_after4", in_ready, 1);
      for (int p = 0; p < 4; p++) send_beat(beats[1][p]);
      in_valid = 1'b0;
      wait_drain();

      // Abort after two beats, then a clean tile
      abort0 = abort_cnt;
      hs0 = hs_cnt;
      send_beat(beats[0][0]);
      send_beat(beats[0][1]);
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("abort_pulse", in_abort, 1);
      check("abort_no_out", out_valid, 0);
      send_tile(0);
      in_valid = 1'b0;
      check("abort_once", abort_cnt - abort0, 1);
      wait_drain();
      check("abort_words", hs_cnt - hs0, 4);

      // Asynchronous reset mid-drain
      out_ready = 1'b0;
      send_tile(0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2;
      rstn = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_in_ready", in_ready, 1);
      check("arst_out_data", out_data, 0);
      check("arst_out_idx", out_idx, 0);
      check("arst_out_last", out_last, 0);
      check("arst_in_abort", in_abort, 0);
      sb_q.delete();
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;
      send_tile(0);
      in_valid = 1'b0;
      check("post_rst_valid", out_valid, 1);
      wait_drain();

      check("sb_empty", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
